// File: rtl/id_ex_skid_stage.sv
// ID/EX stage: main + skid register pair, 1-cycle latency, registered in_ready (= !skid valid).
// An out_ready stall parks one beat in skid; flush drops both entries and zeroes the bundle.
module id_ex_skid_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 5,
  parameter int CTRL_W     = 9,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_rd1,
  input  logic [DATA_WIDTH-1:0] in_rd2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [DATA_WIDTH-1:0] in_pc4,
  input  logic [ADDR_W-1:0]     in_rs,
  input  logic [ADDR_W-1:0]     in_rt,
  input  logic [ADDR_W-1:0]     in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [DATA_WIDTH-1:0] out_rd1,
  output logic [DATA_WIDTH-1:0] out_rd2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [DATA_WIDTH-1:0] out_pc4,
  output logic [ADDR_W-1:0]     out_rs,
  output logic [ADDR_W-1:0]     out_rt,
  output logic [ADDR_W-1:0]     out_rd,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc4;
    logic [ADDR_W-1:0]     rs;
    logic [ADDR_W-1:0]     rt;
    logic [ADDR_W-1:0]     rd;
  } beat_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  beat_t            in_beat;
  beat_t            main_q, main_d;
  beat_t            skid_q, skid_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             in_rdy_q, in_rdy_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             in_fire;
  logic             out_fire;

  assign in_beat = '{ctrl: in_ctrl, rd1: in_rd1, rd2: in_rd2, imm: in_imm,
                     pc4: in_pc4, rs: in_rs, rt: in_rt, rd: in_rd};

  assign in_fire  = in_valid & in_rdy_q;
  assign out_fire = main_vld_q & out_ready;

  // Empty entries always hold zero so the output bundle decodes as a NOP.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_d     = '0;
      skid_d     = '0;
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q) begin
      if (in_fire) begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end
    end else if (out_fire) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_d     = '0;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        main_d     = in_beat;
      end else begin
        main_d     = '0;
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
  end

  always_comb begin
    in_rdy_d     = !skid_vld_d;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!main_vld_q && bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + 1'b1;
    if (flush && flush_cnt_q != CNT_MAX)        flush_cnt_d  = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_vld_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      in_rdy_q     <= 1'b1;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_vld_q   <= main_vld_d;
      skid_vld_q   <= skid_vld_d;
      in_rdy_q     <= in_rdy_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign in_ready   = in_rdy_q;
  assign out_valid  = main_vld_q;
  assign out_ctrl   = main_q.ctrl;
  assign out_rd1    = main_q.rd1;
  assign out_rd2    = main_q.rd2;
  assign out_imm    = main_q.imm;
  assign out_pc4    = main_q.pc4;
  assign out_rs     = main_q.rs;
  assign out_rt     = main_q.rt;
  assign out_rd     = main_q.rd;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Bench for id_ex_skid_stage: directed scenarios plus random traffic, scored against
// a FIFO-occupancy model (capacity 2) and an independent CNT_W=3 instance for saturation.
module tb_id_ex_skid_stage;

  typedef logic [151:0] vec_t;

  logic        clk, rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [8:0]  in_ctrl, out_ctrl;
  logic [31:0] in_rd1, in_rd2, in_imm, in_pc4;
  logic [31:0] out_rd1, out_rd2, out_imm, out_pc4;
  logic [4:0]  in_rs, in_rt, in_rd, out_rs, out_rt, out_rd;
  logic [15:0] bubble_cnt, flush_cnt;

  logic        sat_in_ready, sat_out_valid;
  logic [8:0]  sat_ctrl;
  logic [31:0] sat_rd1, sat_rd2, sat_imm, sat_pc4;
  logic [4:0]  sat_rs, sat_rt, sat_rd;
  logic [2:0]  sat_bubble, sat_flush;

  int   errors = 0;
  int   checks = 0;
  vec_t exp_q[$];
  int   m_bub = 0;
  int   m_fl  = 0;

  id_ex_skid_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm), .in_pc4(in_pc4),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
    .out_pc4(out_pc4), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_skid_stage #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(1'b0), .in_ready(sat_in_ready),
    .in_ctrl('0), .in_rd1('0), .in_rd2('0), .in_imm('0), .in_pc4('0),
    .in_rs('0), .in_rt('0), .in_rd('0),
    .out_valid(sat_out_valid), .out_ready(1'b1),
    .out_ctrl(sat_ctrl), .out_rd1(sat_rd1), .out_rd2(sat_rd2), .out_imm(sat_imm),
    .out_pc4(sat_pc4), .out_rs(sat_rs), .out_rt(sat_rt), .out_rd(sat_rd),
    .bubble_cnt(sat_bubble), .flush_cnt(sat_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t in_vec();
    return {in_ctrl, in_rd1, in_rd2, in_imm, in_pc4, in_rs, in_rt, in_rd};
  endfunction

  function automatic vec_t out_vec();
    return {out_ctrl, out_rd1, out_rd2, out_imm, out_pc4, out_rs, out_rt, out_rd};
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic rand_payload();
    in_ctrl = 9'($urandom);
    in_rd2  = $urandom;
    in_imm  = $urandom;
    in_pc4  = $urandom;
    in_rs   = 5'($urandom);
    in_rt   = 5'($urandom);
    in_rd   = 5'($urandom);
  endtask

  task automatic drive_beat(input logic [31:0] rd1);
    rand_payload();
    in_rd1   = rd1;
    in_valid = 1'b1;
  endtask

  task automatic drive_idle();
    rand_payload();
    in_rd1   = $urandom;
    in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: the stage is a 2-deep FIFO; everything is judged from occupancy.
  always @(negedge clk) begin
    int occ;
    if (rst) begin
      exp_q.delete();
      m_bub = 0;
      m_fl  = 0;
    end else begin
      occ = exp_q.size();
      chk("out_valid", out_valid, occ != 0);
      chk("in_ready", in_ready, occ < 2);
      chk("bubble_cnt", bubble_cnt, m_bub);
      chk("flush_cnt", flush_cnt, m_fl);
      if (!out_valid) begin
        chk("idle_payload_zero", out_vec(), '0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", out_vec(), $time);
        end else begin
          chk("beat_order", out_vec(), exp_q.pop_front());
        end
      end
      if (occ == 0 && m_bub != 65535) m_bub++;
      if (flush) begin
        if (m_fl != 65535) m_fl++;
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back(in_vec());
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset then stream, with bubble accounting.
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    drive_idle();
    cyc(5);
    drive_beat(32'h11); cyc(1);
    chk("stream_a", {out_valid, out_rd1}, {1'b1, 32'h11});
    drive_beat(32'h22); cyc(1);
    chk("stream_b", {out_valid, out_rd1}, {1'b1, 32'h22});
    drive_beat(32'h33); cyc(1);
    chk("stream_c", {out_valid, out_rd1}, {1'b1, 32'h33});
    chk("stream_ready", in_ready, 1'b1);
    drive_idle(); cyc(2);
    chk("bubble_7", bubble_cnt, 16'd7);

    // Stall fills the skid; C waits at the input.
    out_ready = 1'b0;
    drive_beat(32'hA); cyc(1);
    drive_beat(32'hB); cyc(1);
    chk("stall_ready_low", in_ready, 1'b0);
    drive_beat(32'hC); cyc(2);
    chk("stall_hold_a", {out_valid, out_rd1, in_ready}, {1'b1, 32'hA, 1'b0});
    out_ready = 1'b1; cyc(1);
    chk("stall_b", {out_rd1, in_ready}, {32'hB, 1'b1});
    cyc(1);
    chk("stall_c", out_rd1, 32'hC);
    drive_idle(); cyc(1);
    chk("stall_drained", out_valid, 1'b0);

    // Flush with full skid and a beat offered in the same cycle.
    out_ready = 1'b0;
    drive_beat(32'hA); cyc(1);
    drive_beat(32'hB); cyc(1);
    drive_beat(32'hD); flush = 1'b1; cyc(1);
    flush = 1'b0; drive_idle();
    chk("flush_out", {out_valid, out_vec()}, {1'b0, 152'h0});
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_cnt_1", flush_cnt, 16'd1);
    out_ready = 1'b1; cyc(2);
    chk("flush_no_d", out_valid, 1'b0);

    // Asynchronous reset between edges while stalled and full.
    out_ready = 1'b0;
    drive_beat(32'h55); cyc(1);
    drive_beat(32'h66); cyc(1);
    drive_idle();
    #2 rst = 1'b1;
    #1;
    chk("arst_out", {out_valid, out_vec()}, {1'b0, 152'h0});
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_cnts", {bubble_cnt, flush_cnt}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Random traffic against the model.
    repeat (400) begin
      if ($urandom_range(0, 1) == 1) drive_beat($urandom); else drive_idle();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cyc(1);
    end
    flush = 1'b0; out_ready = 1'b1; drive_idle();
    begin
      int budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        cyc(1);
        budget--;
      end
      chk("drain_empty", exp_q.size(), 0);
    end

    // Saturation on the CNT_W=3 instance.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(4);
    chk("sat_bubble_4", sat_bubble, 3'd4);
    cyc(6);
    chk("sat_bubble_7", sat_bubble, 3'd7);
    cyc(5);
    chk("sat_bubble_hold", sat_bubble, 3'd7);
    chk("sat_flush_0", sat_flush, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Parametrised decode→execute pipeline stage with a valid/ready handshake, a 2-entry skid buffer, flush (bubble insertion) and saturating bubble/flush counters.
- Carries the ID/EX bundle: control word, two register-read operands, sign-extended immediate, Rs/Rt/Rd addresses and PC+4.
- Lets the hazard unit stall execute via out_ready without a combinational ready path back into decode.

Parameters:
DATA_WIDTH, 32, operand/immediate/PC width
ADDR_W, 5, register address width
CTRL_W, 9, control word width (RegWrite, MemtoReg, MemWrite, alu_control[2:0], alu_src, RegDst, Branch)
CNT_W, 16, counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of the stage (branch/load-use bubble)
in_valid  in  1  decode presents a beat
in_ready  out  1  stage accepts a beat; registered
in_ctrl  in  CTRL_W  control word
in_rd1, in_rd2  in  DATA_WIDTH each  register-file read data
in_imm  in  DATA_WIDTH  sign-extended immediate
in_pc4  in  DATA_WIDTH  PC+4
in_rs, in_rt, in_rd  in  ADDR_W each  register addresses
out_valid  out  1  execute beat valid
out_ready  in  1  execute consumes beat
out_ctrl, out_rd1, out_rd2, out_imm, out_pc4, out_rs, out_rt, out_rd  out  widths as inputs  registered bundle
bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating
flush_cnt  out  CNT_W  flush cycles, saturating

Behaviour:
- Storage: main register (drives outputs) plus skid register, each with its own valid bit. No combinational path from input to output; latency 1 cycle when not stalled.
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_valid, registered. Reset value 1.
- Per-edge rules, no flush:
  - main empty: in_fire loads main.
  - main valid, out_fire, skid empty: main takes the input beat if in_fire, else main empties.
  - main valid, out_fire, skid valid: skid moves to main and skid empties. in_fire cannot occur here.
  - main valid, !out_ready, in_fire: beat goes to skid; in_ready drops on the next cycle.
  - Otherwise hold.
- Ordering: beats leave in strict arrival order. No beat is duplicated or dropped except by flush.
- Output zeroing: the out_* payload is all-zero whenever out_valid=0, so control bits read as a NOP.
- Flush (highest priority, synchronous):
  - Clears both valid bits and zeroes main and skid payloads.
  - A beat offered in the flush cycle is discarded even if in_ready=1.
  - After flush: out_valid=0 and in_ready=1 on the next cycle.
- Reset (async, any time including mid-stall): all valid bits 0, all payloads 0, in_ready=1, both counters 0. Takes effect immediately, independent of clk.
- bubble_cnt: increments on every edge where out_valid=0 (sampled before the edge) and rst=0. Holds at 2^CNT_W-1.
- flush_cnt: increments on every edge where flush=1. Holds at max.
- Both counters are read-only and cleared only by rst.

Test Plan:
- Reset then stream: rst pulse, then in_valid=1 with in_rd1=0x0000_0011,0x22,0x33 and out_ready=1 → out_rd1 shows 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first beat; in_ready stays 1.
- Stall with skid: main holds A, out_ready=0, offer B → B held in skid, in_ready=0 next cycle; C held off at input. out_ready=1 → A, then B, then C; C appears only after in_ready returns to 1.
- Flush with full skid: main=A, skid=B, flush=1 with beat D offered → next cycle out_valid=0, all out_* = 0, in_ready=1, D never appears, flush_cnt=1.
- Async reset mid-stall: main and skid full; assert rst between clock edges → outputs zero and in_ready=1 immediately, without waiting for an edge; counters 0.
- Bubble count: 5 idle cycles after reset, then 3 valid beats, then 2 idle → bubble_cnt=7.
- Saturation: CNT_W=3, 10 idle cycles → bubble_cnt=7, held.
